// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI burst encodings, sequencer state type and small pack/unpack helpers
// used by the burst sequencer and its address calculator.
package tvip_axi_types_pkg;

  localparam int TVIP_AXI_4KB_BOUNDARY = 4096;

  typedef enum logic [2:0] {
    TVIP_AXI_BURST_SIZE_1_BYTE    = 3'd0,
    TVIP_AXI_BURST_SIZE_2_BYTES   = 3'd1,
    TVIP_AXI_BURST_SIZE_4_BYTES   = 3'd2,
    TVIP_AXI_BURST_SIZE_8_BYTES   = 3'd3,
    TVIP_AXI_BURST_SIZE_16_BYTES  = 3'd4,
    TVIP_AXI_BURST_SIZE_32_BYTES  = 3'd5,
    TVIP_AXI_BURST_SIZE_64_BYTES  = 3'd6,
    TVIP_AXI_BURST_SIZE_128_BYTES = 3'd7
  } tvip_axi_burst_size;

  typedef enum logic [1:0] {
    TVIP_AXI_FIXED_BURST        = 2'b00,
    TVIP_AXI_INCREMENTING_BURST = 2'b01,
    TVIP_AXI_WRAPPING_BURST     = 2'b10
  } tvip_axi_burst_type;

  typedef logic [7:0] tvip_axi_burst_length;

  typedef enum logic {
    SEQ_IDLE   = 1'b0,
    SEQ_ACTIVE = 1'b1
  } tvip_axi_seq_state;

  function automatic int unsigned unpack_burst_size(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

  function automatic logic [2:0] pack_burst_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

  function automatic int unsigned unpack_burst_length(input tvip_axi_burst_length length);
    return {24'd0, length} + 32'd1;
  endfunction

  function automatic tvip_axi_burst_length pack_burst_length(input int unsigned beats);
    return tvip_axi_burst_length'(beats - 32'd1);
  endfunction

endpackage

// File: rtl/tvip_axi_beat_address_calc.sv
// Combinational beat address step (FIXED/INCR/WRAP) and byte-lane strobe for the
// resulting address. With advance_i low the current address passes through.
module tvip_axi_beat_address_calc
  import tvip_axi_types_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 64
) (
  input  logic [ADDRESS_WIDTH-1:0] cur_address_i,
  input  logic                     advance_i,
  input  logic [2:0]               size_i,
  input  logic [1:0]               burst_i,
  input  logic [ADDRESS_WIDTH-1:0] wrap_lo_i,
  input  logic [ADDRESS_WIDTH-1:0] wrap_bytes_i,
  output logic [ADDRESS_WIDTH-1:0] beat_address_o,
  output logic [DATA_WIDTH/8-1:0]  beat_strobe_o
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(DATA_BYTES - 1);

  logic [ADDRESS_WIDTH-1:0] bytes;
  logic [ADDRESS_WIDTH-1:0] step_address;
  logic [ADDRESS_WIDTH-1:0] next_address;
  logic [ADDRESS_WIDTH-1:0] lane_lo;
  logic [ADDRESS_WIDTH-1:0] lane_hi;

  always_comb begin
    bytes        = ADDRESS_WIDTH'(1) << size_i;
    step_address = cur_address_i + bytes;
    next_address = (cur_address_i & ~(bytes - ADDRESS_WIDTH'(1))) + bytes;
    case (burst_i)
      TVIP_AXI_FIXED_BURST:    next_address = cur_address_i;
      TVIP_AXI_WRAPPING_BURST: next_address = (step_address == wrap_lo_i + wrap_bytes_i)
                                              ? wrap_lo_i : step_address;
      default:                 next_address = (cur_address_i & ~(bytes - ADDRESS_WIDTH'(1))) + bytes;
    endcase
    beat_address_o = advance_i ? next_address : cur_address_i;

    // Lanes run from the beat's own offset up to the end of its size-aligned group.
    lane_lo = beat_address_o & LANE_MASK;
    lane_hi = ((beat_address_o & ~(bytes - ADDRESS_WIDTH'(1))) & LANE_MASK) + bytes - ADDRESS_WIDTH'(1);
    beat_strobe_o = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      beat_strobe_o[i] = (ADDRESS_WIDTH'(i) >= lane_lo) && (ADDRESS_WIDTH'(i) <= lane_hi);
    end
  end

endmodule

// File: rtl/tvip_axi_burst_sequencer.sv
// Turns one AXI4 burst command into registered per-beat address/strobe/LAST,
// dropping and flagging commands that break burst legality rules.
module tvip_axi_burst_sequencer
  import tvip_axi_types_pkg::*;
#(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [7:0]               cmd_length,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  output logic                     cmd_error,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [ADDRESS_WIDTH-1:0] beat_address,
  output logic [7:0]               beat_index,
  output logic [DATA_WIDTH/8-1:0]  beat_strobe,
  output logic                     beat_last,
  output logic                     busy
);

  localparam int DATA_BYTES    = DATA_WIDTH / 8;
  localparam int SIZE_MAX      = $clog2(DATA_BYTES);
  localparam int BOUNDARY_BITS = $clog2(TVIP_AXI_4KB_BOUNDARY);

  // Handshakes: a transfer happens on a rising aclk edge where valid && ready;
  // beat_* stay stable while beat_valid && !beat_ready.
  tvip_axi_seq_state state_q, state_d;

  logic                     valid_q, last_q, error_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, wrap_lo_q, wrap_bytes_q;
  logic [7:0]               index_q, length_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic [DATA_BYTES-1:0]    strobe_q;

  logic                     accept, illegal, load, beat_step, beat_done;
  logic [ADDRESS_WIDTH-1:0] cmd_bytes, cmd_total_bytes, cmd_aligned, cmd_wrap_lo;
  logic [ADDRESS_WIDTH:0]   incr_first, incr_end;
  logic [8:0]               cmd_beats;
  logic                     crosses_4kb, wrap_len_ok, wrap_unaligned, size_too_big;
  logic [ADDRESS_WIDTH-1:0] calc_address;
  logic [DATA_BYTES-1:0]    calc_strobe;

  always_comb begin
    cmd_bytes       = ADDRESS_WIDTH'(1) << cmd_size;
    cmd_beats       = {1'b0, cmd_length} + 9'd1;
    cmd_total_bytes = ADDRESS_WIDTH'(cmd_beats) << cmd_size;
    cmd_aligned     = cmd_address & ~(cmd_bytes - ADDRESS_WIDTH'(1));
    cmd_wrap_lo     = cmd_address & ~(cmd_total_bytes - ADDRESS_WIDTH'(1));
    incr_first      = {1'b0, cmd_aligned};
    incr_end        = incr_first + {1'b0, cmd_total_bytes} - (ADDRESS_WIDTH+1)'(1);
    crosses_4kb     = (incr_end >> BOUNDARY_BITS) != (incr_first >> BOUNDARY_BITS);
    wrap_len_ok     = cmd_length inside {8'd1, 8'd3, 8'd7, 8'd15};
    wrap_unaligned  = (cmd_address & (cmd_bytes - ADDRESS_WIDTH'(1))) != '0;
    size_too_big    = int'(cmd_size) > SIZE_MAX;
    illegal = (cmd_burst == 2'b11) || size_too_big
           || ((cmd_burst == TVIP_AXI_WRAPPING_BURST) && (!wrap_len_ok || wrap_unaligned))
           || ((cmd_burst == TVIP_AXI_FIXED_BURST) && (cmd_length > 8'd15))
           || ((cmd_burst == TVIP_AXI_INCREMENTING_BURST) && crosses_4kb);
  end

  assign beat_done = valid_q && beat_ready && last_q;
  assign beat_step = valid_q && beat_ready && !last_q;
  assign cmd_ready = (state_q == SEQ_IDLE) || beat_done;
  assign accept    = cmd_valid && cmd_ready;
  assign load      = accept && !illegal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:   if (load) state_d = SEQ_ACTIVE;
      SEQ_ACTIVE: if (beat_done && !load) state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) state_q <= SEQ_IDLE;
    else           state_q <= state_d;
  end

  // On load the calculator passes cmd_address through to get beat 0's strobe.
  tvip_axi_beat_address_calc #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_calc (
    .cur_address_i  (load ? cmd_address : addr_q),
    .advance_i      (!load),
    .size_i         (load ? cmd_size : size_q),
    .burst_i        (burst_q),
    .wrap_lo_i      (wrap_lo_q),
    .wrap_bytes_i   (wrap_bytes_q),
    .beat_address_o (calc_address),
    .beat_strobe_o  (calc_strobe)
  );

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      wrap_lo_q    <= '0;
      wrap_bytes_q <= '0;
      index_q      <= '0;
      length_q     <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      strobe_q     <= '0;
    end else begin
      error_q <= accept && illegal;
      if (load) begin
        valid_q      <= 1'b1;
        id_q         <= cmd_id;
        length_q     <= cmd_length;
        size_q       <= cmd_size;
        burst_q      <= cmd_burst;
        wrap_lo_q    <= cmd_wrap_lo;
        wrap_bytes_q <= cmd_total_bytes;
        addr_q       <= calc_address;
        strobe_q     <= calc_strobe;
        index_q      <= 8'd0;
        last_q       <= (cmd_length == 8'd0);
      end else if (beat_step) begin
        addr_q   <= calc_address;
        strobe_q <= calc_strobe;
        index_q  <= index_q + 8'd1;
        last_q   <= ((index_q + 8'd1) == length_q);
      end else if (beat_done) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign cmd_error    = error_q;
  assign beat_valid   = valid_q;
  assign beat_id      = id_q;
  assign beat_address = addr_q;
  assign beat_index   = index_q;
  assign beat_strobe  = strobe_q;
  assign beat_last    = last_q;
  assign busy         = (state_q == SEQ_ACTIVE);

endmodule
